alu_share_ctrl: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit, 3-bit-opcode combinational ALU among NUM_REQ requesters.
- Each requester issues {A, B, op} with a valid/ready handshake.
- The controller grants one requester, holds registered operands on the ALU for one cycle, captures the result, and returns it on a single response channel tagged with the requester ID.
- It sits between the core's execution requesters and the shared ALU instance.

---
 rtl/alu_share_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter/sequencer sharing one 8-bit ALU among NUM_REQ requesters.
// Define ALU_SHARE_STATUS_EN to add the registered rsp_zero / rsp_dz status outputs.
module alu_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  input  logic [7:0]           alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result
`ifdef ALU_SHARE_STATUS_EN
  ,
  output logic                 rsp_zero,
  output logic                 rsp_dz
`endif
);

  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_ZERO = 3'b111;
  // Wide enough for pointer+1 plus a search offset of up to NUM_REQ-1.
  localparam int CNT_W = ID_W + 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      id_q;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_found;
  logic [CNT_W-1:0]     start;
  logic [CNT_W-1:0]     cand;
  logic [NUM_REQ-1:0]   valid_rot;
  logic [7:0]           sel_a;
  logic [7:0]           sel_b;
  logic [2:0]           sel_op;
  logic                 accept;
  logic                 retire;
  logic                 div_zero;
  logic [7:0]           capture;

  // Rotate so bit 0 of valid_rot is the requester just after the last grant.
  assign start     = CNT_W'(ptr_q) + CNT_W'(1);
  assign valid_rot = NUM_REQ'({req_valid, req_valid} >> start);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = start + CNT_W'(k);
      if (cand >= CNT_W'(NUM_REQ)) begin
        cand = cand - CNT_W'(NUM_REQ);
      end
      if (!grant_found && valid_rot[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_a  = req_a[8*k +: 8];
        sel_b  = req_b[8*k +: 8];
        sel_op = req_op[3*k +: 3];
      end
    end
  end

  // A divide by zero never trusts the ALU output.
  assign div_zero = (alu_op == OP_DIV) && (alu_b == 8'h00);
  assign capture  = div_zero ? 8'h00 : alu_result;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    retire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          accept  = rst_n;
          state_d = EXEC;
          if (rst_n) begin
            req_ready = NUM_REQ'(1) << grant_idx;
          end
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= grant_idx;
        id_q  <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OP_ZERO;
    end else if (accept) begin
      alu_a  <= sel_a;
      alu_b  <= sel_b;
      alu_op <= sel_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else if (state_q == EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= id_q;
      rsp_result <= capture;
    end else if (retire) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_SHARE_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
      rsp_dz   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_zero <= (capture == 8'h00);
      rsp_dz   <= div_zero;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed + randomized self-checking bench for alu_share_ctrl.
// Define ALU_SHARE_STATUS_EN to also check rsp_zero / rsp_dz.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0] req_op;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic [2:0]           alu_op;
  logic [7:0]           alu_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_result;
`ifdef ALU_SHARE_STATUS_EN
  logic                 rsp_zero;
  logic                 rsp_dz;
`endif

  int checks = 0;
  int failures = 0;
  int last_grant;

  logic [7:0] op_a    [NUM_REQ];
  logic [7:0] op_b    [NUM_REQ];
  logic [2:0] op_code [NUM_REQ];

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; a divide by zero yields junk the controller must ignore.
  function automatic logic [7:0] alu_func(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return prod[7:0];
      3'b011:  return (b == 8'h00) ? 8'hFF : a / b;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_func(alu_a, alu_b, alu_op);

  alu_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_result(rsp_result)
`ifdef ALU_SHARE_STATUS_EN
    ,
    .rsp_zero(rsp_zero),
    .rsp_dz(rsp_dz)
`endif
  );

  function automatic logic [7:0] expect_result(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] op);
    if (op == 3'b011 && b == 8'h00) return 8'h00;
    return alu_func(a, b, op);
  endfunction

  // Round-robin reference: first valid requester after the last grant, wrapping.
  function automatic int rr_next(input logic [NUM_REQ-1:0] v);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (last_grant + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valids);
    req_valid = valids;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[8*i +: 8]  = op_a[i];
      req_b[8*i +: 8]  = op_b[i];
      req_op[3*i +: 3] = op_code[i];
    end
  endtask

  task automatic randomize_req(input int i);
    op_a[i]    = 8'($urandom);
    op_code[i] = 3'($urandom_range(0, 7));
    op_b[i]    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_alu_a"}, alu_a, 0);
    checkOutput({tag, "_alu_b"}, alu_b, 0);
    checkOutput({tag, "_alu_op"}, alu_op, 3'b111);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_id"}, rsp_id, 0);
    checkOutput({tag, "_rsp_result"}, rsp_result, 0);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
`ifdef ALU_SHARE_STATUS_EN
    checkOutput({tag, "_rsp_zero"}, rsp_zero, 0);
    checkOutput({tag, "_rsp_dz"}, rsp_dz, 0);
`endif
  endtask

  // One full transaction from an idle controller: grant, execute, respond (with stall), retire.
  task automatic serve_one(input logic [NUM_REQ-1:0] valids, input int stall);
    int g;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] er;
    logic [2:0] eo;
    applyStimulus(valids);
    rsp_ready = 1'b0;
    #1;
    checkOutput("idle_rsp_valid", rsp_valid, 0);
    g = rr_next(valids);
    if (g < 0) begin
      checkOutput("idle_no_ready", req_ready, 0);
      tick();
      return;
    end
    checkOutput("grant", req_ready, 32'(1) << g);
    ea = op_a[g];
    eb = op_b[g];
    eo = op_code[g];
    er = expect_result(ea, eb, eo);
    tick();
    last_grant = g;
    randomize_req(g);
    applyStimulus(valids);
    #1;
    checkOutput("exec_alu_a", alu_a, ea);
    checkOutput("exec_alu_b", alu_b, eb);
    checkOutput("exec_alu_op", alu_op, eo);
    checkOutput("exec_rsp_valid", rsp_valid, 0);
    checkOutput("exec_req_ready", req_ready, 0);
    tick();
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall);
      #1;
      checkOutput("resp_valid", rsp_valid, 1);
      checkOutput("resp_id", rsp_id, g);
      checkOutput("resp_result", rsp_result, er);
      checkOutput("resp_req_ready", req_ready, 0);
`ifdef ALU_SHARE_STATUS_EN
      checkOutput("resp_zero", rsp_zero, (er == 8'h00));
      checkOutput("resp_dz", rsp_dz, (eo == 3'b011 && eb == 8'h00));
`endif
      tick();
    end
    rsp_ready = 1'b0;
    #1;
    checkOutput("retire_valid", rsp_valid, 0);
  endtask

  initial begin
    int g;
    for (int i = 0; i < NUM_REQ; i++) randomize_req(i);
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus('1);
    tick();
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    last_grant = NUM_REQ - 1;
    $display("[TB] reset released");

    op_a[0] = 8'd20; op_b[0] = 8'd7; op_code[0] = 3'b001;
    serve_one(4'b0001, 0);

    op_code[3] = 3'b111;
    serve_one(4'b1000, 0);

    op_a[0] = 8'd5;   op_b[0] = 8'd3;   op_code[0] = 3'b000;
    op_a[1] = 8'd16;  op_b[1] = 8'd17;  op_code[1] = 3'b010;
    op_a[2] = 8'hF0;  op_b[2] = 8'h3C;  op_code[2] = 3'b110;
    op_a[3] = 8'h5A;  op_b[3] = 8'hA5;  op_code[3] = 3'b111;
    for (int i = 0; i < 5; i++) serve_one(4'b1111, 0);

    serve_one(4'b1111, 5);

    op_a[1] = 8'd200; op_b[1] = 8'd0; op_code[1] = 3'b011;
    serve_one(4'b0010, 0);
    op_a[1] = 8'd200; op_b[1] = 8'd7; op_code[1] = 3'b011;
    serve_one(4'b0010, 1);

    $display("[TB] reset during EXEC");
    applyStimulus(4'b0001);
    #1;
    g = rr_next(4'b0001);
    checkOutput("mid_grant", req_ready, 32'(1) << g);
    tick();
    last_grant = g;
    rst_n = 1'b0;
    applyStimulus(4'b0011);
    tick();
    check_reset_values("mid_reset");
    rst_n = 1'b1;
    last_grant = NUM_REQ - 1;
    serve_one(4'b0011, 0);

    for (int i = 0; i < 4; i++) serve_one(4'b1010, 0);

    $display("[TB] randomized phase");
    for (int i = 0; i < 60; i++) begin
      serve_one(NUM_REQ'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
